// File: rtl/pci_bench_arbiter.sv
// ---------------------------------------------------------------------------
// pci_bench_arbiter
//
// Central PCI arbiter for the bench. Up to 8 masters share one segment
// through active-low REQ#/GNT# pairs. A new grant is only placed onto an
// idle bus (FRAME# and IRDY# both high). With no requests the bus is parked
// on PARK_MASTER. A granted master that leaves the idle bus unused for
// IDLE_TIMEOUT clocks loses its grant.
//
// Ports
//   CLK          PCI clock, rising edge
//   RST          asynchronous active-high reset
//   REQ[N-1:0]   per-master request, active-low
//   GNT[N-1:0]   per-master grant, active-low, registered
//   FRAME        bus FRAME#, active-low
//   IRDY         bus IRDY#, active-low
//   ARB_OWNER    index of the current or last grantee
//   ARB_VALID    high while any GNT bit is low
//   ARB_TIMEOUT  one-clock pulse when a grant is withdrawn for non-use
//   DBG_STATE    current arbiter state encoding (debug observation)
//
// Handshake: a master holds REQ[i] low for as long as it wants the bus.
// GNT[i] low means it may start a cycle by driving FRAME low on an idle
// bus. The arbiter drops GNT[i] at the edge where it samples FRAME low,
// so exactly one transaction is started per grant; REQ[i] going high
// while granted (without FRAME) is taken as a withdrawn request.
// ---------------------------------------------------------------------------
module pci_bench_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int PARK_MASTER  = 0,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_MASTERS-1:0] REQ,
    output logic [NUM_MASTERS-1:0] GNT,
    input  logic                   FRAME,
    input  logic                   IRDY,
    output logic [2:0]             ARB_OWNER,
    output logic                   ARB_VALID,
    output logic                   ARB_TIMEOUT,
    output logic [2:0]             DBG_STATE
);

    localparam int         TW       = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [2:0] PARK_IDX = 3'(PARK_MASTER);

    typedef enum logic [2:0] {
        S_PARK_WAIT = 3'd0,
        S_PARK      = 3'd1,
        S_GRANT     = 3'd2,
        S_BUSY      = 3'd3,
        S_HANDOFF   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [2:0]             owner_q, owner_d;
    logic [2:0]             rr_q, rr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   tout_q, tout_d;
    logic [2:0]             hof_idx_q, hof_idx_d;
    logic                   hof_park_q, hof_park_d;

    logic [NUM_MASTERS-1:0] req_low;
    logic [NUM_MASTERS-1:0] owner_mask;
    logic [NUM_MASTERS-1:0] other_req;
    logic                   any_req;
    logic                   any_other;
    logic                   owner_req;
    logic                   frame_low;
    logic                   bus_idle;
    logic [2:0]             pick;
    logic [2:0]             pick_other;

    // First requester scanning upward from ptr+1, wrapping; ptr itself is
    // checked last. Returns ptr when nothing is requesting.
    function automatic logic [2:0] rr_pick(input logic [NUM_MASTERS-1:0] rl,
                                           input logic [2:0] ptr);
        logic [2:0]             res;
        logic                   found;
        logic [NUM_MASTERS-1:0] sh;
        int                     idx;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(ptr) + i) % NUM_MASTERS;
            sh  = rl >> idx;
            if (!found && sh[0]) begin
                res   = 3'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Active-low grant vector with only bit idx asserted.
    function automatic logic [NUM_MASTERS-1:0] gnt_for(input logic [2:0] idx);
        logic [NUM_MASTERS-1:0] v;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            v[i] = (idx != 3'(i));
        end
        return v;
    endfunction

    always_comb begin
        req_low    = ~REQ;
        any_req    = |req_low;
        owner_mask = ~gnt_for(owner_q);
        other_req  = req_low & ~owner_mask;
        any_other  = |other_req;
        owner_req  = |(req_low & owner_mask);
        frame_low  = ~FRAME;
        bus_idle   = FRAME & IRDY;
        pick       = rr_pick(req_low, rr_q);
        pick_other = rr_pick(other_req, owner_q);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        timer_d    = timer_q;
        tout_d     = 1'b0;
        hof_idx_d  = hof_idx_q;
        hof_park_d = hof_park_q;

        case (state_q)
            S_PARK_WAIT: begin
                if (any_req && bus_idle) begin
                    state_d = S_GRANT;
                    gnt_d   = gnt_for(pick);
                    owner_d = pick;
                    rr_d    = pick;
                    timer_d = '0;
                end else begin
                    state_d = S_PARK;
                    gnt_d   = gnt_for(PARK_IDX);
                    owner_d = PARK_IDX;
                end
            end

            S_PARK: begin
                if (frame_low) begin
                    state_d = S_BUSY;
                    gnt_d   = '1;
                end else if (any_req && bus_idle) begin
                    if (pick == PARK_IDX) begin
                        // Parked master is the winner: keep GNT low, no gap.
                        state_d = S_GRANT;
                        owner_d = PARK_IDX;
                        rr_d    = PARK_IDX;
                        timer_d = '0;
                    end else begin
                        state_d    = S_HANDOFF;
                        gnt_d      = '1;
                        hof_idx_d  = pick;
                        hof_park_d = 1'b0;
                    end
                end
            end

            S_HANDOFF: begin
                // Target was latched on entry; requests are not re-checked.
                if (hof_park_q) begin
                    state_d = S_PARK;
                    gnt_d   = gnt_for(PARK_IDX);
                    owner_d = PARK_IDX;
                end else begin
                    state_d = S_GRANT;
                    gnt_d   = gnt_for(hof_idx_q);
                    owner_d = hof_idx_q;
                    rr_d    = hof_idx_q;
                    timer_d = '0;
                end
            end

            S_GRANT: begin
                if (frame_low) begin
                    // Drop the grant as the cycle starts; FRAME beats timeout.
                    state_d = S_BUSY;
                    gnt_d   = '1;
                end else if (!owner_req) begin
                    if (any_other) begin
                        state_d    = S_HANDOFF;
                        gnt_d      = '1;
                        hof_idx_d  = pick_other;
                        hof_park_d = 1'b0;
                    end else if (owner_q == PARK_IDX) begin
                        state_d = S_PARK;
                    end else begin
                        state_d    = S_HANDOFF;
                        gnt_d      = '1;
                        hof_idx_d  = PARK_IDX;
                        hof_park_d = 1'b1;
                    end
                end else if (bus_idle) begin
                    if (timer_q == TW'(IDLE_TIMEOUT - 1)) begin
                        // Owner is masked out so it is skipped on the way out.
                        tout_d     = 1'b1;
                        rr_d       = owner_q;
                        state_d    = S_HANDOFF;
                        gnt_d      = '1;
                        hof_idx_d  = any_other ? pick_other : PARK_IDX;
                        hof_park_d = !any_other;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            S_BUSY: begin
                // The idle cycle already on the bus serves as turnaround.
                if (bus_idle) begin
                    if (any_req) begin
                        state_d = S_GRANT;
                        gnt_d   = gnt_for(pick);
                        owner_d = pick;
                        rr_d    = pick;
                        timer_d = '0;
                    end else begin
                        state_d = S_PARK;
                        gnt_d   = gnt_for(PARK_IDX);
                        owner_d = PARK_IDX;
                    end
                end
            end

            default: begin
                state_d = S_PARK_WAIT;
                gnt_d   = '1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_PARK_WAIT;
            gnt_q      <= '1;
            owner_q    <= PARK_IDX;
            rr_q       <= PARK_IDX;
            timer_q    <= '0;
            tout_q     <= 1'b0;
            hof_idx_q  <= PARK_IDX;
            hof_park_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            timer_q    <= timer_d;
            tout_q     <= tout_d;
            hof_idx_q  <= hof_idx_d;
            hof_park_q <= hof_park_d;
        end
    end

    assign GNT         = gnt_q;
    assign ARB_OWNER   = owner_q;
    assign ARB_VALID   = ~&gnt_q;
    assign ARB_TIMEOUT = tout_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_pci_bench_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pci_bench_arbiter
//
// Directed bench for pci_bench_arbiter with 4 masters, park on master 0,
// idle timeout 16. Inputs change on the falling edge, outputs are read on
// the falling edge, so each check sees the result of the preceding rising
// edge.
// ---------------------------------------------------------------------------
module tb_pci_bench_arbiter;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] REQ;
    logic [N-1:0] GNT;
    logic         FRAME;
    logic         IRDY;
    logic [2:0]   ARB_OWNER;
    logic         ARB_VALID;
    logic         ARB_TIMEOUT;
    logic [2:0]   DBG_STATE;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [2:0]   exp_q[$];
    logic [N-1:0] prev_gnt = '1;

    // clock / reset
    always #5 CLK = ~CLK;

    pci_bench_arbiter #(
        .NUM_MASTERS (N),
        .PARK_MASTER (0),
        .IDLE_TIMEOUT(16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ        (REQ),
        .GNT        (GNT),
        .FRAME      (FRAME),
        .IRDY       (IRDY),
        .ARB_OWNER  (ARB_OWNER),
        .ARB_VALID  (ARB_VALID),
        .ARB_TIMEOUT(ARB_TIMEOUT),
        .DBG_STATE  (DBG_STATE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] gnt_pat(input int idx);
        logic [N-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    // driver: one single-data-phase transaction by the granted master
    task automatic master_cycle(input bit drop_req);
        FRAME = 1'b0;
        IRDY  = 1'b0;
        if (drop_req) REQ = '1;
        @(negedge CLK);
        check("mc_busy", 32'(GNT), 32'(4'b1111));
        FRAME = 1'b1;
        @(negedge CLK);
        check("mc_last", 32'(GNT), 32'(4'b1111));
        IRDY = 1'b1;
    endtask

    // bus invariants, every cycle out of reset
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            check("one_gnt", 32'($countones(~GNT) <= 1), 32'd1);
            check("no_direct_switch",
                  32'((prev_gnt != '1) && (GNT != '1) && (prev_gnt != GNT)), 32'd0);
        end
        prev_gnt = GNT;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST   = 1'b1;
        REQ   = '1;
        FRAME = 1'b1;
        IRDY  = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_gnt",   32'(GNT), 32'(4'b1111));
        check("rst_owner", 32'(ARB_OWNER), 32'd0);
        check("rst_valid", 32'(ARB_VALID), 32'd0);
        check("rst_tout",  32'(ARB_TIMEOUT), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("park_gnt",   32'(GNT), 32'(4'b1110));
        check("park_owner", 32'(ARB_OWNER), 32'd0);
        check("park_valid", 32'(ARB_VALID), 32'd1);

        // single request from master 2
        REQ = 4'b1011;
        @(negedge CLK);
        check("sr_gap", 32'(GNT), 32'(4'b1111));
        @(negedge CLK);
        check("sr_gnt",   32'(GNT), 32'(4'b1011));
        check("sr_owner", 32'(ARB_OWNER), 32'd2);
        FRAME = 1'b0;
        IRDY  = 1'b0;
        REQ   = '1;
        @(negedge CLK);
        check("sr_busy", 32'(GNT), 32'(4'b1111));
        check("sr_busy_owner", 32'(ARB_OWNER), 32'd2);
        FRAME = 1'b1;
        @(negedge CLK);
        check("sr_busy_last", 32'(GNT), 32'(4'b1111));
        IRDY = 1'b1;
        @(negedge CLK);
        check("sr_park",       32'(GNT), 32'(4'b1110));
        check("sr_park_owner", 32'(ARB_OWNER), 32'd0);

        // reset in the middle of a grant to master 1
        REQ = 4'b1101;
        @(negedge CLK);
        check("rs_gap", 32'(GNT), 32'(4'b1111));
        @(negedge CLK);
        check("rs_gnt1", 32'(GNT), 32'(4'b1101));
        #2 RST = 1'b1;
        #1;
        check("rs_async_gnt",   32'(GNT), 32'(4'b1111));
        check("rs_async_owner", 32'(ARB_OWNER), 32'd0);
        check("rs_async_valid", 32'(ARB_VALID), 32'd0);
        REQ = '1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("rs_park",       32'(GNT), 32'(4'b1110));
        check("rs_park_owner", 32'(ARB_OWNER), 32'd0);

        // round-robin with every master requesting
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        REQ = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            int         polls;
            logic [2:0] e;
            e     = exp_q.pop_front();
            polls = 0;
            do begin
                @(negedge CLK);
                polls++;
            end while (GNT == '1 && polls < 8);
            check("rr_gnt",     32'(GNT), 32'(gnt_pat(int'(e))));
            check("rr_owner",   32'(ARB_OWNER), 32'(e));
            check("rr_latency", 32'(polls), (k == 0) ? 32'd2 : 32'd1);
            master_cycle(k == 4);
        end
        @(negedge CLK);
        check("rr_park", 32'(GNT), 32'(4'b1110));

        // back-to-back: master 2 requests during master 1's transaction
        REQ = 4'b1101;
        @(negedge CLK);
        check("b2b_gap", 32'(GNT), 32'(4'b1111));
        @(negedge CLK);
        check("b2b_gnt1", 32'(GNT), 32'(4'b1101));
        FRAME = 1'b0;
        IRDY  = 1'b0;
        REQ   = 4'b1011;
        @(negedge CLK);
        check("b2b_busy", 32'(GNT), 32'(4'b1111));
        FRAME = 1'b1;
        @(negedge CLK);
        check("b2b_busy_last", 32'(GNT), 32'(4'b1111));
        IRDY = 1'b1;
        @(negedge CLK);
        check("b2b_gnt2",  32'(GNT), 32'(4'b1011));
        check("b2b_owner", 32'(ARB_OWNER), 32'd2);

        // master 2 withdraws its request before starting
        REQ = '1;
        @(negedge CLK);
        check("wd_handoff", 32'(GNT), 32'(4'b1111));
        check("wd_tout0",   32'(ARB_TIMEOUT), 32'd0);
        @(negedge CLK);
        check("wd_park",  32'(GNT), 32'(4'b1110));
        check("wd_owner", 32'(ARB_OWNER), 32'd0);
        check("wd_tout1", 32'(ARB_TIMEOUT), 32'd0);

        // idle timeout: master 3 never starts, master 1 also waiting
        REQ = 4'b0101;
        @(negedge CLK);
        check("to_gap", 32'(GNT), 32'(4'b1111));
        @(negedge CLK);
        check("to_gnt3",  32'(GNT), 32'(4'b0111));
        check("to_owner", 32'(ARB_OWNER), 32'd3);
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            check("to_hold_gnt",  32'(GNT), 32'(4'b0111));
            check("to_hold_tout", 32'(ARB_TIMEOUT), 32'd0);
        end
        @(negedge CLK);
        check("to_pulse",     32'(ARB_TIMEOUT), 32'd1);
        check("to_pulse_gnt", 32'(GNT), 32'(4'b1111));
        @(negedge CLK);
        check("to_pulse_end", 32'(ARB_TIMEOUT), 32'd0);
        check("to_next_gnt",  32'(GNT), 32'(4'b1101));
        check("to_next_own",  32'(ARB_OWNER), 32'd1);
        REQ = '1;
        @(negedge CLK);
        check("to_end_gap", 32'(GNT), 32'(4'b1111));
        @(negedge CLK);
        check("to_end_park", 32'(GNT), 32'(4'b1110));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
